// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM bank write-only exerciser: FSM encoding,
// default geometry/timeout constants and the pattern LFSR step function.
package jtsdram_pkg;

    // Default word-address width of one SDRAM bank
    localparam int JTSDRAM_AW   = 22;
    // Default number of cycles to wait for rdy before declaring a timeout
    localparam int JTSDRAM_TOUT = 255;
    // Non-zero reset value of the pacing LFSR
    localparam logic [15:0] JTSDRAM_LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_RDY = 3'd2,
        GAP      = 3'd3,
        DONE     = 3'd4
    } wo_state_e;

    // Fibonacci LFSR, taps 16/14/13/11 (maximal length)
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic fb;
        fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
        return {cur[14:0], fb};
    endfunction

endpackage

// File: rtl/jtsdram_rnd.sv
// Free-running 16-bit pseudo-random source used to size idle gaps between
// writes. Advances on every cycle where adv is high.
module jtsdram_rnd
    import jtsdram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next LFSR value: step when advancing, hold otherwise
    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // LFSR register, reset to a non-zero seed so it never locks up
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= JTSDRAM_LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/jtsdram_bank_wo.sv
// Full-bank write pass generator for SDRAM testing. Writes seed^addr to every
// word of the bank, paced either by LVBL (active video) or by random gaps.
// Optional feature: define JTSDRAM_WR_TIMEOUT_EN to give up on a write whose
// rdy does not arrive within TOUT cycles, flagging it on tout_err.
module jtsdram_bank_wo
    import jtsdram_pkg::*;
#(
    parameter int AW   = JTSDRAM_AW,
    parameter int TOUT = JTSDRAM_TOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LVBL,
    input  logic          start,
    input  logic          slow,
    input  logic [15:0]   seed,
    output logic [AW-1:0] addr,
    output logic          wr,
    output logic [15:0]   din,
    output logic [1:0]    din_m,
    input  logic          ack,
    input  logic          rdy,
    output logic          busy,
    output logic          done,
    output logic          tout_err
);

    wo_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [3:0]    gap_cnt_q, gap_cnt_d;
    logic          wr_cplt;
    logic          start_ok;
    logic          tout_hit;
    logic [15:0]   lfsr;
    logic [15:0]   addr16;
    logic [11:0]   unused_lfsr;

    jtsdram_rnd u_rnd (
        .clk  (clk),
        .rst  (rst),
        .adv  (1'b1),
        .lfsr (lfsr)
    );

    assign unused_lfsr = lfsr[15:4];

    // A new pass may only begin when no write is outstanding
    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

    // Zero-extend or truncate the address to 16 bits for the data pattern
    generate
        if (AW >= 16) begin : g_addr_trunc
            assign addr16 = addr_q[15:0];
        end else begin : g_addr_ext
            assign addr16 = {{(16 - AW){1'b0}}, addr_q};
        end
    endgenerate

`ifdef JTSDRAM_WR_TIMEOUT_EN
    localparam int TW = (TOUT < 2) ? 1 : $clog2(TOUT + 1);

    logic [TW-1:0] tout_cnt_q, tout_cnt_d;
    logic          tout_err_q, tout_err_d;

    // The TOUT-th consecutive WAIT_RDY cycle without rdy ends the wait
    assign tout_hit = (state_q == WAIT_RDY) && (tout_cnt_q == TW'(TOUT - 1));

    // Timeout counter runs only while waiting; error is sticky until a new pass
    always_comb begin
        tout_cnt_d = '0;
        tout_err_d = tout_err_q;
        if ((state_q == WAIT_RDY) && !rdy && !tout_hit) begin
            tout_cnt_d = tout_cnt_q + 1'b1;
        end
        if (start_ok) begin
            tout_err_d = 1'b0;
        end
        if (tout_hit && !rdy) begin
            tout_err_d = 1'b1;
        end
    end

    // Timeout state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tout_cnt_q <= '0;
            tout_err_q <= 1'b0;
        end else begin
            tout_cnt_q <= tout_cnt_d;
            tout_err_q <= tout_err_d;
        end
    end

    assign tout_err = tout_err_q;
`else
    logic [31:0] unused_tout;

    assign unused_tout = TOUT;
    assign tout_hit    = 1'b0;
    assign tout_err    = 1'b0;
`endif

    // Next-state logic; a completed write either finishes the pass or moves
    // to the next word, going straight to REQ only when pacing allows
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        busy_d    = busy_q;
        done_d    = done_q;
        gap_cnt_d = gap_cnt_q;
        wr_cplt   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = REQ;
                    addr_d  = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            REQ: begin
                // ack and rdy together mean the write already finished
                if (ack && rdy) begin
                    wr_cplt = 1'b1;
                end else if (ack) begin
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (rdy || tout_hit) begin
                    wr_cplt = 1'b1;
                end
            end
            GAP: begin
                if (slow) begin
                    if (gap_cnt_q == 4'd0) begin
                        state_d = REQ;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 4'd1;
                    end
                end else if (LVBL) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wr_cplt) begin
            if (addr_q == '1) begin
                state_d = DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                addr_d = addr_q + 1'b1;
                if (!slow && LVBL) begin
                    state_d = REQ;
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = lfsr[3:0];
                end
            end
        end
    end

    // Main state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            gap_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign addr  = addr_q;
    assign wr    = (state_q == REQ);
    assign din   = seed ^ addr16;
    assign din_m = 2'b00;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_jtsdram_bank_wo.sv
// Directed self-checking bench for jtsdram_bank_wo (AW=4, TOUT=8).
// Build with or without JTSDRAM_WR_TIMEOUT_EN; expectations follow the macro.
module tb_jtsdram_bank_wo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        LVBL = 1'b1;
    logic        start = 1'b0;
    logic        slow = 1'b0;
    logic [15:0] seed = 16'hA5A5;
    logic [3:0]  addr;
    logic        wr;
    logic [15:0] din;
    logic [1:0]  din_m;
    logic        ack = 1'b0;
    logic        rdy = 1'b0;
    logic        busy;
    logic        done;
    logic        tout_err;

    int          checks = 0;
    int          failures = 0;
    logic [3:0]  exp_addr = 4'd0;
    logic [15:0] ref_lfsr;

    always #5 clk = ~clk;

    jtsdram_bank_wo #(
        .AW   (4),
        .TOUT (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .LVBL     (LVBL),
        .start    (start),
        .slow     (slow),
        .seed     (seed),
        .addr     (addr),
        .wr       (wr),
        .din      (din),
        .din_m    (din_m),
        .ack      (ack),
        .rdy      (rdy),
        .busy     (busy),
        .done     (done),
        .tout_err (tout_err)
    );

    // Reference LFSR (taps 16/14/13/11), stepped every cycle out of reset
    always @(posedge clk) begin
        if (rst) begin
            ref_lfsr <= jtsdram_pkg::JTSDRAM_LFSR_SEED;
        end else begin
            ref_lfsr <= {ref_lfsr[14:0],
                         ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr = 4'd0;
    endtask

    // One write handshake: ack ack_d cycles and rdy rdy_d cycles after wr.
    // Returns the LFSR low nibble present in the cycle rdy is sampled.
    task automatic xfer(input int ack_d, input int rdy_d, output logic [3:0] lf);
        $display("xfer addr=%0h din=%h", addr, din);
        check("wr_req", wr, 1);
        check("addr", addr, exp_addr);
        check("din", din, seed ^ {12'h000, exp_addr});
        for (int i = 0; i < ack_d; i++) begin
            @(negedge clk);
            check("wr_hold", wr, 1);
        end
        ack = 1'b1;
        rdy = (rdy_d == ack_d);
        lf = ref_lfsr[3:0];
        @(negedge clk);
        ack = 1'b0;
        rdy = 1'b0;
        if (rdy_d > ack_d) begin
            check("wr_drop", wr, 0);
            for (int i = ack_d + 1; i < rdy_d; i++) begin
                @(negedge clk);
            end
            lf = ref_lfsr[3:0];
            rdy = 1'b1;
            @(negedge clk);
            rdy = 1'b0;
        end
        exp_addr = exp_addr + 4'd1;
    endtask

    initial begin
        logic [3:0] lf;
        int         n;
        int         wr_seen;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_wr", wr, 0);
        check("rst_addr", addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tout", tout_err, 0);
        check("din_m", din_m, 0);

        // Full pass, ack after 1 cycle, rdy after 3
        pulse_start();
        check("start_busy", busy, 1);
        for (int w = 0; w < 16; w++) begin
            xfer(1, 3, lf);
        end
        check("p1_done", done, 1);
        check("p1_busy", busy, 0);
        check("p1_wr", wr, 0);

        // Full pass with ack and rdy in the same cycle as wr
        pulse_start();
        check("p2_done_clr", done, 0);
        for (int w = 0; w < 16; w++) begin
            xfer(0, 0, lf);
            if (w < 15) begin
                check("fast_wr", wr, 1);
                check("fast_addr", addr, exp_addr);
            end
        end
        check("p2_done", done, 1);

        // Random-gap pacing
        slow = 1'b1;
        pulse_start();
        for (int w = 0; w < 4; w++) begin
            xfer(1, 3, lf);
            n = 0;
            while (!wr && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("gap_len", n - 1, {28'h0, lf});
        end

        // LVBL pacing: blanking holds off the next request
        slow = 1'b0;
        LVBL = 1'b0;
        xfer(1, 3, lf);
        wr_seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (wr) wr_seen++;
            @(negedge clk);
        end
        check("lvbl_hold", wr_seen, 0);
        LVBL = 1'b1;
        @(negedge clk);
        check("lvbl_rise", wr, 1);

        // Advance to address 7, start ignored while waiting, then reset
        xfer(1, 3, lf);
        xfer(1, 3, lf);
        check("at7", addr, 7);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_wr", wr, 0);
        check("ign_addr", addr, 7);
        check("ign_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_wr", wr, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("post_rst_wr", wr, 0);

        // Reset while wr is asserted drops it on the next cycle
        pulse_start();
        check("req_wr", wr, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("req_rst_wr", wr, 0);

        // rdy withheld after ack
        pulse_start();
        check("to_wr", wr, 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (7) @(negedge clk);
        check("to_early", tout_err, 0);
`ifdef JTSDRAM_WR_TIMEOUT_EN
        @(negedge clk);
        check("to_err", tout_err, 1);
        check("to_addr", addr, 1);
        check("to_wr_next", wr, 1);
`else
        repeat (300) @(negedge clk);
        check("stall_tout", tout_err, 0);
        check("stall_wr", wr, 0);
        check("stall_busy", busy, 1);
        check("stall_addr", addr, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
